// File: rtl/load_store_unit_if.sv
// Request/response handshake and data_memory port of the load/store unit.
// master: the requester plus the memory; slave: the load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_data, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage sequencer between the ALU and a word-wide data memory.
// Adds sub-word loads with extension and sub-word stores by read-modify-write.
// Misaligned requests complete with an error and never touch memory.

// One byte lane of the store merge: take the store byte where enabled,
// otherwise keep the byte read back from memory.
module lsu_byte_lane (
  input  logic       en,
  input  logic [7:0] st,
  input  logic [7:0] rd,
  output logic [7:0] mg
);
  assign mg = en ? st : rd;
endmodule

module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_e;

  state_e state_q, state_d;

  // Request captured at acceptance; wdata_q later holds the merged RMW word.
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        misaligned;
  logic [1:0]  byte_lane;
  logic [1:0]  half_lo;
  logic [1:0]  half_hi;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;

  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [NUM_LANES-1:0][7:0] st_lanes;
  logic [NUM_LANES-1:0][7:0] mg_lanes;
  logic [NUM_LANES-1:0]      lane_en;

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;

  // Alignment check on the incoming request; byte ops can never fault.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_op)
      OP_LW, OP_SW:         misaligned = |bus.req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = bus.req_addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Physical lane (bits [8j+7:8j]) holding the addressed byte/halfword.
  // Big-endian puts byte offset k in lane 3-k, which is simply ~k.
  assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign half_lo   = BIG_ENDIAN ? {~addr_q[1], 1'b0} : {addr_q[1], 1'b0};
  assign half_hi   = {half_lo[1], 1'b1};

  assign rd_lanes = bus.mem_read_data;
  assign byte_val = rd_lanes[byte_lane];
  assign half_val = {rd_lanes[half_hi], rd_lanes[half_lo]};

  // Extend the extracted lane according to the load flavour.
  always_comb begin
    load_val = bus.mem_read_data;
    case (op_q)
      OP_LH:   load_val = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_val = {16'h0000, half_val};
      OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_val = {24'h000000, byte_val};
      default: load_val = bus.mem_read_data;
    endcase
  end

  // Lanes overwritten by a sub-word store.
  always_comb begin
    lane_en = '0;
    case (op_q)
      OP_SB: lane_en[byte_lane] = 1'b1;
      OP_SH: begin
        lane_en[half_lo] = 1'b1;
        lane_en[half_hi] = 1'b1;
      end
      default: lane_en = '0;
    endcase
  end

  // Replicate the store data so every candidate lane sees the right byte;
  // the upper halfword byte is the lower address in big-endian order.
  assign st_lanes = (op_q == OP_SH) ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_byte_lane u_lane (
      .en (lane_en[i]),
      .st (st_lanes[i]),
      .rd (rd_lanes[i]),
      .mg (mg_lanes[i])
    );
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and all outputs, decoded purely from the state so that
  // MEM_WRITE and friends fall with the asynchronous reset.
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (misaligned)                                 state_d = RESP;
          else if (bus.req_op == OP_SW)                   state_d = WRITE;
          else if (bus.req_op == OP_SH || bus.req_op == OP_SB) state_d = RMW_READ;
          else                                            state_d = LOAD;
        end
      end
      LOAD: begin
        mem_read    = 1'b1;
        mem_address = {2'b00, addr_q[31:2]};
        state_d     = RESP;
      end
      RMW_READ: begin
        mem_read    = 1'b1;
        mem_address = {2'b00, addr_q[31:2]};
        state_d     = WRITE;
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = {2'b00, addr_q[31:2]};
        mem_write_data = wdata_q;
        state_d        = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request, then the load result or the merged store word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          err_q   <= misaligned;
          rdata_q <= '0;
        end
        LOAD:     rdata_q <= load_val;
        RMW_READ: wdata_q <= mg_lanes;
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_rdata     = resp_rdata;
  assign bus.resp_err       = resp_err;
  assign bus.mem_address    = mem_address;
  assign bus.mem_write_data = mem_write_data;
  assign bus.mem_write      = mem_write;
  assign bus.mem_read       = mem_read;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for
// back-to-back and reset-abort, then random requests against a byte-level model.
module tb_load_store_unit;
  localparam bit BE = 1'b1;
  localparam logic [2:0] LW = 0, LH = 1, LHU = 2, LB = 3, LBU = 4, SW = 5, SH = 6, SB = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if ifc ();

  load_store_unit #(.BIG_ENDIAN(BE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  int proto_bad = 0;
  logic prev_resp = 1'b0;

  assign ifc.mem_read_data = mem[ifc.mem_address[5:0]];

  // Word memory written by the DUT.
  always @(posedge clk) begin
    if (ifc.mem_write) begin
      mem[ifc.mem_address[5:0]] <= ifc.mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (ifc.resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Output invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.mem_read && ifc.mem_write) proto_bad++;
    if (!ifc.mem_write && ifc.mem_write_data != 0) proto_bad++;
    if (!ifc.mem_read && !ifc.mem_write && ifc.mem_address != 0) proto_bad++;
    if (!ifc.resp_valid && (ifc.resp_rdata != 0 || ifc.resp_err)) proto_bad++;
    if (ifc.resp_valid && prev_resp) proto_bad++;
    prev_resp = ifc.resp_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed view of memory) -------
  function automatic int shamt(input logic [31:0] a);
    return BE ? 8 * (3 - int'(a[1:0])) : 8 * int'(a[1:0]);
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    return 8'(ref_mem[a[7:2]] >> shamt(a));
  endfunction

  task automatic wbyte(input logic [31:0] a, input logic [7:0] v);
    ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~(32'hFF << shamt(a))) | (32'(v) << shamt(a));
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int nrd, output int nwr);
    int sz;
    logic [15:0] h;
    logic [7:0] b;
    sz = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    err = (int'(a[1:0]) % sz) != 0;
    rd = '0; nrd = 0; nwr = 0; lat = 1;
    if (!err) begin
      lat = (op == SH || op == SB) ? 3 : 2;
      nrd = (op == SW) ? 0 : 1;
      nwr = (op >= SW) ? 1 : 0;
      h = BE ? {rbyte(a), rbyte(a + 1)} : {rbyte(a + 1), rbyte(a)};
      b = rbyte(a);
      case (op)
        LW:  rd = BE ? {rbyte(a), rbyte(a+1), rbyte(a+2), rbyte(a+3)}
                     : {rbyte(a+3), rbyte(a+2), rbyte(a+1), rbyte(a)};
        LH:  rd = {{16{h[15]}}, h};
        LHU: rd = {16'h0, h};
        LB:  rd = {{24{b[7]}}, b};
        LBU: rd = {24'h0, b};
        SW: for (int i = 0; i < 4; i++)
              wbyte(a + 32'(i), BE ? 8'(wd >> (24 - 8*i)) : 8'(wd >> (8*i)));
        SH: begin
          wbyte(a,     BE ? wd[15:8] : wd[7:0]);
          wbyte(a + 1, BE ? wd[7:0]  : wd[15:8]);
        end
        default: wbyte(a, wd[7:0]);
      endcase
    end
  endtask

  // ---------------- request driver -----------------------------------------
  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [31:0] wword,
                         output int abad);
    int n;
    rd = '0; err = 1'b0; nrd = 0; nwr = 0; wword = '0; abad = 0;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_addr = a; ifc.req_wdata = wd;
    n = 0;
    while (!ifc.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_before_accept", 32'(ifc.req_ready), 32'd1);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    ifc.req_op = 3'($urandom); ifc.req_addr = $urandom; ifc.req_wdata = $urandom;
    lat = 1;
    while (!ifc.resp_valid && lat < 20) begin
      if (ifc.mem_read) nrd++;
      if (ifc.mem_write) begin nwr++; wword = ifc.mem_write_data; end
      if ((ifc.mem_read || ifc.mem_write) && ifc.mem_address != {2'b00, a[31:2]}) abad++;
      @(posedge clk); #1;
      lat++;
    end
    rd = ifc.resp_rdata;
    err = ifc.resp_err;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] wword;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] rd, ww, e_rd;
  logic err, e_err;
  int lat, nrd, nwr, abad, e_lat, e_nrd, e_nwr, n, rbad, w0, r0, diff;
  logic [2:0] rop;
  logic [31:0] raddr, rwd;

  initial begin
    ifc.req_valid = 1'b0; ifc.req_op = '0; ifc.req_addr = '0; ifc.req_wdata = '0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[4] = 32'h80FF7F01; ref_mem[4] = 32'h80FF7F01;
    mem[5] = 32'h0;        ref_mem[5] = 32'h0;

    // Reset values
    #12;
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("rst_resp_rdata", ifc.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(ifc.resp_err), 32'd0);
    chk("rst_mem_rw", {30'd0, ifc.mem_read, ifc.mem_write}, 32'd0);
    chk("rst_mem_address", ifc.mem_address, 32'd0);
    chk("rst_mem_wdata", ifc.mem_write_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors: op, addr, wdata, rdata, err, latency, written word
    tbl.push_back('{LB,  32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 2, 32'h0});
    tbl.push_back('{LBU, 32'h10, 32'h0, 32'h00000080, 1'b0, 2, 32'h0});
    tbl.push_back('{LH,  32'h12, 32'h0, 32'h00007F01, 1'b0, 2, 32'h0});
    tbl.push_back('{LH,  32'h10, 32'h0, 32'hFFFF80FF, 1'b0, 2, 32'h0});
    tbl.push_back('{LW,  32'h10, 32'h0, 32'h80FF7F01, 1'b0, 2, 32'h0});
    tbl.push_back('{LHU, 32'h10, 32'h0, 32'h000080FF, 1'b0, 2, 32'h0});
    tbl.push_back('{LB,  32'h13, 32'h0, 32'h00000001, 1'b0, 2, 32'h0});
    tbl.push_back('{LB,  32'h11, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 32'h0});
    tbl.push_back('{LBU, 32'h12, 32'h0, 32'h0000007F, 1'b0, 2, 32'h0});
    tbl.push_back('{SW,  32'h12, 32'h11111111, 32'h0, 1'b1, 1, 32'h0});
    tbl.push_back('{LH,  32'h11, 32'h0, 32'h0, 1'b1, 1, 32'h0});
    tbl.push_back('{LW,  32'h11, 32'h0, 32'h0, 1'b1, 1, 32'h0});
    tbl.push_back('{LHU, 32'h13, 32'h0, 32'h0, 1'b1, 1, 32'h0});
    tbl.push_back('{SH,  32'h13, 32'h2222, 32'h0, 1'b1, 1, 32'h0});
    tbl.push_back('{SB,  32'h13, 32'h000000AB, 32'h0, 1'b0, 3, 32'h80FF7FAB});
    tbl.push_back('{LW,  32'h10, 32'h0, 32'h80FF7FAB, 1'b0, 2, 32'h0});
    tbl.push_back('{SW,  32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2, 32'h80FF7F01});
    tbl.push_back('{SH,  32'h10, 32'h00001234, 32'h0, 1'b0, 3, 32'h12347F01});
    tbl.push_back('{LW,  32'h10, 32'h0, 32'h12347F01, 1'b0, 2, 32'h0});
    tbl.push_back('{SW,  32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF});
    tbl.push_back('{SB,  32'h16, 32'h000000C3, 32'h0, 1'b0, 3, 32'hDEADC3EF});
    tbl.push_back('{SH,  32'h16, 32'hFFFF5678, 32'h0, 1'b0, 3, 32'hDEAD5678});
    tbl.push_back('{LW,  32'h14, 32'h0, 32'hDEAD5678, 1'b0, 2, 32'h0});
    tbl.push_back('{LH,  32'h16, 32'h0, 32'h00005678, 1'b0, 2, 32'h0});
    tbl.push_back('{LB,  32'h15, 32'h0, 32'hFFFFFFAD, 1'b0, 2, 32'h0});

    foreach (tbl[i]) begin
      model(tbl[i].op, tbl[i].addr, tbl[i].wdata, e_rd, e_err, e_lat, e_nrd, e_nwr);
      run_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, rd, err, lat, nrd, nwr, ww, abad);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d_mem_reads", i), 32'(nrd), 32'(e_nrd));
      chk($sformatf("vec%0d_mem_writes", i), 32'(nwr), 32'(e_nwr));
      chk($sformatf("vec%0d_mem_addr", i), 32'(abad), 32'd0);
      if (e_nwr != 0) chk($sformatf("vec%0d_write_word", i), ww, tbl[i].wword);
    end
    chk("word4_after_vectors", mem[4], 32'h12347F01);

    // Back-to-back with REQ_VALID held high: LW 0x10 then LBU 0x13
    mem[4] = 32'h80FF7F01; ref_mem[4] = 32'h80FF7F01;
    @(negedge clk);
    n = 0;
    while (!ifc.req_ready && n < 50) begin @(negedge clk); n++; end
    ifc.req_valid = 1'b1; ifc.req_op = LW; ifc.req_addr = 32'h10; ifc.req_wdata = '0;
    @(posedge clk); #1;
    ifc.req_op = LBU; ifc.req_addr = 32'h13;
    rbad = 0; n = 1;
    while (!ifc.resp_valid && n < 10) begin
      if (ifc.req_ready) rbad++;
      @(posedge clk); #1; n++;
    end
    if (ifc.req_ready) rbad++;
    chk("b2b_first_latency", 32'(n), 32'd2);
    chk("b2b_first_rdata", ifc.resp_rdata, 32'h80FF7F01);
    chk("b2b_ready_low_while_busy", 32'(rbad), 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle_gap_ready", 32'(ifc.req_ready), 32'd1);
    chk("b2b_idle_gap_no_resp", 32'(ifc.resp_valid), 32'd0);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    chk("b2b_second_accepted", 32'(ifc.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_second_resp", 32'(ifc.resp_valid), 32'd1);
    chk("b2b_second_rdata", ifc.resp_rdata, 32'h00000001);

    // Reset during the RMW_READ cycle of SB 0x10
    @(negedge clk);
    n = 0;
    while (!ifc.req_ready && n < 50) begin @(negedge clk); n++; end
    ifc.req_valid = 1'b1; ifc.req_op = SB; ifc.req_addr = 32'h10; ifc.req_wdata = 32'h55;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    chk("abort_in_rmw_read", 32'(ifc.mem_read), 32'd1);
    w0 = wr_cnt; r0 = resp_cnt;
    rst_n = 1'b0; #1;
    chk("abort_mem_write", 32'(ifc.mem_write), 32'd0);
    chk("abort_mem_read", 32'(ifc.mem_read), 32'd0);
    chk("abort_mem_address", ifc.mem_address, 32'd0);
    chk("abort_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("abort_resp", {ifc.resp_rdata[30:0], ifc.resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after_release", 32'(ifc.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("abort_no_resp", 32'(resp_cnt - r0), 32'd0);
    chk("abort_word4_unchanged", mem[4], 32'h80FF7F01);

    // Random requests vs. the model
    for (int t = 0; t < 300; t++) begin
      rop = 3'($urandom_range(0, 7));
      raddr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (rop == LW || rop == SW) raddr[1:0] = 2'b00;
        else if (rop == LH || rop == LHU || rop == SH) raddr[0] = 1'b0;
      end
      rwd = $urandom;
      model(rop, raddr, rwd, e_rd, e_err, e_lat, e_nrd, e_nwr);
      run_req(rop, raddr, rwd, rd, err, lat, nrd, nwr, ww, abad);
      chk($sformatf("rnd%0d_rdata op%0d a%h", t, rop, raddr), rd, e_rd);
      chk($sformatf("rnd%0d_err", t), 32'(err), 32'(e_err));
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_mem_reads", t), 32'(nrd), 32'(e_nrd));
      chk($sformatf("rnd%0d_mem_writes", t), 32'(nwr), 32'(e_nwr));
      chk($sformatf("rnd%0d_mem_addr", t), 32'(abad), 32'd0);
      if (e_nwr != 0) chk($sformatf("rnd%0d_write_word", t), ww, ref_mem[raddr[7:2]]);
    end

    @(posedge clk); #1;
    diff = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("final_memory_words_differing", 32'(diff), 32'd0);
    chk("output_invariant_violations", 32'(proto_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
